// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared constants and helpers for the raster timing generator:
//   - CNT_W: width of the pixel/line counters on the position bus
//   - MAX_TOTAL: largest TOTAL (pixels per line or lines per frame) that fits CNT_W
//   - presets for 1280x720@60 and 640x480@60
//   - sync_bus_t: the {hsync, vsync, de} bundle carried by the delay line
//   - calc_total(): TOTAL of one axis from its four segment lengths
package video_timing_pkg;

    localparam int unsigned CNT_W     = 11;
    localparam int unsigned MAX_TOTAL = 2048;

    // 1280x720@60, 74.25 MHz pixel clock, positive syncs
    localparam int unsigned P720_H_ACTIVE = 1280;
    localparam int unsigned P720_H_FP     = 110;
    localparam int unsigned P720_H_SYNC   = 40;
    localparam int unsigned P720_H_BP     = 220;
    localparam int unsigned P720_V_ACTIVE = 720;
    localparam int unsigned P720_V_FP     = 5;
    localparam int unsigned P720_V_SYNC   = 5;
    localparam int unsigned P720_V_BP     = 20;
    localparam bit          P720_H_POL    = 1'b1;
    localparam bit          P720_V_POL    = 1'b1;

    // 640x480@60, 25.175 MHz pixel clock, negative syncs
    localparam int unsigned P480_H_ACTIVE = 640;
    localparam int unsigned P480_H_FP     = 16;
    localparam int unsigned P480_H_SYNC   = 96;
    localparam int unsigned P480_H_BP     = 48;
    localparam int unsigned P480_V_ACTIVE = 480;
    localparam int unsigned P480_V_FP     = 10;
    localparam int unsigned P480_V_SYNC   = 2;
    localparam int unsigned P480_V_BP     = 33;
    localparam bit          P480_H_POL    = 1'b0;
    localparam bit          P480_V_POL    = 1'b0;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_bus_t;

    // Length of one axis: active area plus front porch, sync and back porch
    function automatic int unsigned calc_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// video_timing_if
// Pixel-position bus between the timing generator and its consumers.
//   i_enable       : advance the raster by one pixel this cycle
//   o_hcnt/o_vcnt  : current column / line
//   o_hsync/o_vsync/o_de : decoded timing, aligned with the counters
//   o_line_start/o_frame_start : one-cycle pulses at column 0 / position (0,0)
//   o_*_d          : sync/DE delayed to match registered consumer outputs
// master: the timing generator. slave: a consumer that also owns the enable.
interface video_timing_if;
    import video_timing_pkg::*;

    logic             i_enable;
    logic [CNT_W-1:0] o_hcnt;
    logic [CNT_W-1:0] o_vcnt;
    logic             o_hsync;
    logic             o_vsync;
    logic             o_de;
    logic             o_line_start;
    logic             o_frame_start;
    logic             o_hsync_d;
    logic             o_vsync_d;
    logic             o_de_d;

    modport master (
        input  i_enable,
        output o_hcnt, o_vcnt, o_hsync, o_vsync, o_de,
        output o_line_start, o_frame_start,
        output o_hsync_d, o_vsync_d, o_de_d
    );

    modport slave (
        output i_enable,
        input  o_hcnt, o_vcnt, o_hsync, o_vsync, o_de,
        input  o_line_start, o_frame_start,
        input  o_hsync_d, o_vsync_d, o_de_d
    );

endinterface

// File: rtl/video_timing_axis_counter.sv
// video_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 on each step,
// wrapping to 0, and decodes the active and sync windows.
//   clk, resetn : pixel clock, async active-low reset
//   step        : advance by one this cycle
//   count       : current position (reset value TOTAL-1, in blanking)
//   wrap        : combinational, high when this step takes count back to 0
//   active      : count < ACTIVE, registered alongside count
//   sync        : POL while count is in [ACTIVE+FP, ACTIVE+FP+SYNC), else !POL
// active/sync are registered from the next count so they describe the same
// position as count in every cycle.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = 1280,
    parameter int unsigned FP     = 110,
    parameter int unsigned SYNC   = 40,
    parameter int unsigned BP     = 220,
    parameter bit          POL    = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    localparam int unsigned      TOTAL      = calc_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam int unsigned      SYNC_START = ACTIVE + FP;
    localparam int unsigned      SYNC_END   = ACTIVE + FP + SYNC;

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [31:0]      count_nxt_w_s;
    logic             at_last_s;
    logic             in_active_s;
    logic             in_sync_s;
    logic             active_r;
    logic             sync_r;

    // Next position and the windows it falls into
    always_comb begin
        at_last_s = (count_r == LAST);
        if (step) begin
            if (at_last_s) begin
                count_nxt_s = {CNT_W{1'b0}};
            end else begin
                count_nxt_s = count_r + CNT_W'(1);
            end
        end else begin
            count_nxt_s = count_r;
        end
        count_nxt_w_s = {{(32 - CNT_W){1'b0}}, count_nxt_s};
        in_active_s   = (count_nxt_w_s < ACTIVE);
        in_sync_s     = (count_nxt_w_s >= SYNC_START) && (count_nxt_w_s < SYNC_END);
    end

    // Position counter and decoded flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_r  <= LAST;
            active_r <= 1'b0;
            sync_r   <= ~POL;
        end else begin
            count_r  <= count_nxt_s;
            active_r <= in_active_s;
            sync_r   <= in_sync_s ? POL : ~POL;
        end
    end

    assign count  = count_r;
    assign wrap   = step & at_last_s;
    assign active = active_r;
    assign sync   = sync_r;

endmodule

// File: rtl/video_timing.sv
// video_timing
// Raster timing generator for the shared pixel-position bus.
//   clk     : pixel clock
//   resetn  : asynchronous active-low reset
//   bus     : video_timing_if.master (enable in; counters, syncs, DE,
//             line/frame pulses and PIPE_DELAY-delayed sync/DE out)
// The horizontal axis steps on i_enable; its wrap steps the vertical axis,
// so vsync and the line number change together at hcnt = 0.
module video_timing
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 1280,
    parameter int unsigned H_FP       = 110,
    parameter int unsigned H_SYNC     = 40,
    parameter int unsigned H_BP       = 220,
    parameter int unsigned V_ACTIVE   = 720,
    parameter int unsigned V_FP       = 5,
    parameter int unsigned V_SYNC     = 5,
    parameter int unsigned V_BP       = 20,
    parameter bit          H_POL      = 1'b1,
    parameter bit          V_POL      = 1'b1,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic          clk,
    input  logic          resetn,
    video_timing_if.master bus
);

    localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam sync_bus_t   IDLE    = '{hsync: ~H_POL, vsync: ~V_POL, de: 1'b0};

    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_chk
        $error("video_timing: H_TOTAL exceeds counter range");
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_chk
        $error("video_timing: V_TOTAL exceeds counter range");
    end
    if (PIPE_DELAY > 4) begin : g_pipe_chk
        $error("video_timing: PIPE_DELAY must be 0..4");
    end

    logic [CNT_W-1:0] h_count_s;
    logic [CNT_W-1:0] v_count_s;
    logic             h_wrap_s;
    logic             v_wrap_s;
    logic             h_active_s;
    logic             v_active_s;
    logic             h_sync_s;
    logic             v_sync_s;
    logic             line_start_r;
    logic             frame_start_r;
    sync_bus_t        now_s;
    sync_bus_t        dly_s;

    video_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .POL (H_POL)
    ) u_h_axis (
        .clk    (clk),
        .resetn (resetn),
        .step   (bus.i_enable),
        .count  (h_count_s),
        .wrap   (h_wrap_s),
        .active (h_active_s),
        .sync   (h_sync_s)
    );

    video_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .POL (V_POL)
    ) u_v_axis (
        .clk    (clk),
        .resetn (resetn),
        .step   (h_wrap_s),
        .count  (v_count_s),
        .wrap   (v_wrap_s),
        .active (v_active_s),
        .sync   (v_sync_s)
    );

    // Line/frame pulses: high only in the cycle after an advance onto column 0 / (0,0)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            line_start_r  <= h_wrap_s;
            frame_start_r <= h_wrap_s & v_wrap_s;
        end
    end

    // Both active flags come from flops clocked on the same edge, so DE is
    // aligned with the counters without another register stage.
    assign now_s = '{hsync: h_sync_s, vsync: v_sync_s, de: h_active_s & v_active_s};

    if (PIPE_DELAY == 0) begin : g_no_delay
        assign dly_s = now_s;
    end else begin : g_delay
        sync_bus_t pipe_r [PIPE_DELAY];

        // Free-running shift register; it ignores i_enable so the delay is in clocks
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
                    pipe_r[i] <= IDLE;
                end
            end else begin
                pipe_r[0] <= now_s;
                for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
                    pipe_r[i] <= pipe_r[i - 1];
                end
            end
        end

        assign dly_s = pipe_r[PIPE_DELAY - 1];
    end

    assign bus.o_hcnt        = h_count_s;
    assign bus.o_vcnt        = v_count_s;
    assign bus.o_hsync       = now_s.hsync;
    assign bus.o_vsync       = now_s.vsync;
    assign bus.o_de          = now_s.de;
    assign bus.o_line_start  = line_start_r;
    assign bus.o_frame_start = frame_start_r;
    assign bus.o_hsync_d     = dly_s.hsync;
    assign bus.o_vsync_d     = dly_s.vsync;
    assign bus.o_de_d        = dly_s.de;

endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing
// Directed bench: a small raster (H 8/2/2/2, V 4/1/1/1, PIPE_DELAY 2) checked
// against a hand-computed vector table and short hand-written sequences, plus
// a default 720p instance with negative hsync.
module tb_video_timing;
    import video_timing_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_s;
    logic rstn_p;

    video_timing_if bus_s();
    video_timing_if bus_p();

    video_timing #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .H_POL (1'b1), .V_POL (1'b1), .PIPE_DELAY (2)
    ) dut_s (
        .clk    (clk),
        .resetn (rstn_s),
        .bus    (bus_s)
    );

    video_timing #(
        .H_POL (1'b0), .PIPE_DELAY (1)
    ) dut_p (
        .clk    (clk),
        .resetn (rstn_p),
        .bus    (bus_p)
    );

    typedef struct {
        logic        en;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
    } vec_t;

    vec_t tbl [18];
    int   n_pass = 0;
    int   n_tot  = 0;

    function automatic vec_t mk(input logic en, input int h, input int v, input logic hs,
                                input logic vs, input logic de, input logic ls, input logic fs);
        vec_t r;
        r.en = en; r.h = 11'(h); r.v = 11'(v);
        r.hs = hs; r.vs = vs; r.de = de; r.ls = ls; r.fs = fs;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_s();
        bus_s.i_enable = 1'b0;
        rstn_s = 1'b0;
        repeat (2) tick();
        rstn_s = 1'b1;
    endtask

    initial begin
        int       fs_cnt;
        int       ls_cnt;
        int       first_low;
        int       last_low;
        int       low_cnt;
        int       n_ls;
        int       ls_t [3];
        logic [2:0] hist [$];
        logic [2:0] cur;
        logic [2:0] dly;

        rstn_s = 1'b0;
        rstn_p = 1'b0;
        bus_s.i_enable = 1'b0;
        bus_p.i_enable = 1'b0;

        //           en   h   v  hs vs de ls fs
        tbl[0]  = mk(1'b1,  0, 0, 0, 0, 1, 1, 1);
        tbl[1]  = mk(1'b0,  0, 0, 0, 0, 1, 0, 0);
        tbl[2]  = mk(1'b0,  0, 0, 0, 0, 1, 0, 0);
        tbl[3]  = mk(1'b0,  0, 0, 0, 0, 1, 0, 0);
        tbl[4]  = mk(1'b1,  1, 0, 0, 0, 1, 0, 0);
        tbl[5]  = mk(1'b1,  2, 0, 0, 0, 1, 0, 0);
        tbl[6]  = mk(1'b1,  3, 0, 0, 0, 1, 0, 0);
        tbl[7]  = mk(1'b1,  4, 0, 0, 0, 1, 0, 0);
        tbl[8]  = mk(1'b1,  5, 0, 0, 0, 1, 0, 0);
        tbl[9]  = mk(1'b1,  6, 0, 0, 0, 1, 0, 0);
        tbl[10] = mk(1'b1,  7, 0, 0, 0, 1, 0, 0);
        tbl[11] = mk(1'b1,  8, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1'b1,  9, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(1'b1, 10, 0, 1, 0, 0, 0, 0);
        tbl[14] = mk(1'b1, 11, 0, 1, 0, 0, 0, 0);
        tbl[15] = mk(1'b1, 12, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(1'b1, 13, 0, 0, 0, 0, 0, 0);
        tbl[17] = mk(1'b1,  0, 1, 0, 0, 1, 1, 0);

        // ---- small raster: reset state ----
        repeat (2) tick();
        #2;
        check("rst_hcnt", int'(bus_s.o_hcnt), 13);
        check("rst_vcnt", int'(bus_s.o_vcnt), 6);
        check("rst_de", int'(bus_s.o_de), 0);
        check("rst_hsync", int'(bus_s.o_hsync), 0);
        check("rst_vsync", int'(bus_s.o_vsync), 0);
        check("rst_ls", int'(bus_s.o_line_start), 0);
        check("rst_fs", int'(bus_s.o_frame_start), 0);
        check("rst_de_d", int'(bus_s.o_de_d), 0);
        tick();
        rstn_s = 1'b1;

        // ---- vector table: first line, including a 3-cycle hold at (0,0) ----
        for (int i = 0; i < 18; i++) begin
            bus_s.i_enable = tbl[i].en;
            tick();
            check($sformatf("v%0d_hcnt", i), int'(bus_s.o_hcnt), int'(tbl[i].h));
            check($sformatf("v%0d_vcnt", i), int'(bus_s.o_vcnt), int'(tbl[i].v));
            check($sformatf("v%0d_hsync", i), int'(bus_s.o_hsync), int'(tbl[i].hs));
            check($sformatf("v%0d_vsync", i), int'(bus_s.o_vsync), int'(tbl[i].vs));
            check($sformatf("v%0d_de", i), int'(bus_s.o_de), int'(tbl[i].de));
            check($sformatf("v%0d_ls", i), int'(bus_s.o_line_start), int'(tbl[i].ls));
            check($sformatf("v%0d_fs", i), int'(bus_s.o_frame_start), int'(tbl[i].fs));
        end

        // ---- vsync window on line 5, changing at hcnt 0 ----
        bus_s.i_enable = 1'b1;
        repeat (55) tick();
        check("vs_pre_hcnt", int'(bus_s.o_hcnt), 13);
        check("vs_pre_vcnt", int'(bus_s.o_vcnt), 4);
        check("vs_pre_vsync", int'(bus_s.o_vsync), 0);
        tick();
        check("vs_on_hcnt", int'(bus_s.o_hcnt), 0);
        check("vs_on_vcnt", int'(bus_s.o_vcnt), 5);
        check("vs_on_vsync", int'(bus_s.o_vsync), 1);
        check("vs_on_de", int'(bus_s.o_de), 0);
        repeat (13) tick();
        check("vs_end_hcnt", int'(bus_s.o_hcnt), 13);
        check("vs_end_vsync", int'(bus_s.o_vsync), 1);
        tick();
        check("vs_off_vcnt", int'(bus_s.o_vcnt), 6);
        check("vs_off_vsync", int'(bus_s.o_vsync), 0);
        repeat (14) tick();
        check("wrap_hcnt", int'(bus_s.o_hcnt), 0);
        check("wrap_vcnt", int'(bus_s.o_vcnt), 0);
        check("wrap_fs", int'(bus_s.o_frame_start), 1);

        // ---- pulse counts over 1000 enabled cycles after the first frame start ----
        reset_s();
        bus_s.i_enable = 1'b1;
        tick();
        check("cnt_first_fs", int'(bus_s.o_frame_start), 1);
        fs_cnt = 0;
        ls_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus_s.o_frame_start) fs_cnt++;
            if (bus_s.o_line_start) ls_cnt++;
        end
        check("cnt_frame_start", fs_cnt, 10);
        check("cnt_line_start", ls_cnt, 71);

        // ---- delay line: _d outputs trail by 2 clocks, across enable gaps ----
        reset_s();
        hist.delete();
        hist.push_back(3'b000);
        hist.push_back(3'b000);
        for (int i = 0; i < 60; i++) begin
            bus_s.i_enable = ((i % 9) < 6) ? 1'b1 : 1'b0;
            tick();
            cur = {bus_s.o_hsync, bus_s.o_vsync, bus_s.o_de};
            dly = {bus_s.o_hsync_d, bus_s.o_vsync_d, bus_s.o_de_d};
            check($sformatf("dly%0d", i), int'(dly), int'(hist[0]));
            void'(hist.pop_front());
            hist.push_back(cur);
        end

        // ---- asynchronous reset at (5,2) mid-frame ----
        reset_s();
        bus_s.i_enable = 1'b1;
        repeat (34) tick();
        check("mid_hcnt", int'(bus_s.o_hcnt), 5);
        check("mid_vcnt", int'(bus_s.o_vcnt), 2);
        #2;
        rstn_s = 1'b0;
        #1;
        check("arst_hcnt", int'(bus_s.o_hcnt), 13);
        check("arst_vcnt", int'(bus_s.o_vcnt), 6);
        check("arst_de", int'(bus_s.o_de), 0);
        check("arst_hsync", int'(bus_s.o_hsync), 0);
        check("arst_vsync", int'(bus_s.o_vsync), 0);
        check("arst_de_d", int'(bus_s.o_de_d), 0);
        tick();
        rstn_s = 1'b1;
        tick();
        check("rel_hcnt", int'(bus_s.o_hcnt), 0);
        check("rel_vcnt", int'(bus_s.o_vcnt), 0);
        check("rel_fs", int'(bus_s.o_frame_start), 1);
        bus_s.i_enable = 1'b0;

        // ---- 720p, negative hsync ----
        check("p_rst_hcnt", int'(bus_p.o_hcnt), 1649);
        check("p_rst_vcnt", int'(bus_p.o_vcnt), 749);
        check("p_rst_hsync", int'(bus_p.o_hsync), 1);
        check("p_rst_vsync", int'(bus_p.o_vsync), 0);
        rstn_p = 1'b1;
        bus_p.i_enable = 1'b1;
        first_low = -1;
        last_low  = -1;
        low_cnt   = 0;
        n_ls      = 0;
        ls_t[0] = -1; ls_t[1] = -1; ls_t[2] = -1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (bus_p.o_line_start && n_ls < 3) begin
                ls_t[n_ls] = i;
                n_ls++;
            end
            if (n_ls == 1 && !bus_p.o_hsync) begin
                if (first_low < 0) first_low = int'(bus_p.o_hcnt);
                last_low = int'(bus_p.o_hcnt);
                low_cnt++;
            end
        end
        check("p_first_fs_at", ls_t[0], 0);
        check("p_hs_low_first", first_low, 1390);
        check("p_hs_low_last", last_low, 1429);
        check("p_hs_low_width", low_cnt, 40);
        check("p_line_count", n_ls, 3);
        check("p_line_spacing1", ls_t[1] - ls_t[0], 1650);
        check("p_line_spacing2", ls_t[2] - ls_t[1], 1650);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
